// File: rtl/emergency_preempt.sv
// Emergency-vehicle detector conditioner: sync + debounce + one-pulse + cooldown (PREEMPT_REPEAT_EN re-fires while held).
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from sensor, 1 edge from manual_req; no backpressure, outputs registered.
module emergency_preempt #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 36,
  parameter int REPEAT_CYCLES   = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_raw,
  input  logic       manual_req,
  output logic       emergency,
  output logic       busy,
  output logic [7:0] preempt_count
);

  typedef enum logic [2:0] {IDLE, QUALIFY, FIRE, HOLD, COOLDOWN} state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYCLES);
  localparam logic [7:0] REP_LAST  = 8'(REPEAT_CYCLES - 1);
  localparam bit         DEB_ONE   = (DEBOUNCE_CYCLES == 1);
  localparam bit         COOL_NONE = (COOLDOWN_CYCLES == 0);

  state_t                 state, state_nxt;
  logic [7:0]             counter, counter_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sensor_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
    end
  end

  assign sensor_sync = sync_q[SYNC_STAGES-1];

`ifndef PREEMPT_REPEAT_EN
  logic unused_rep;
  assign unused_rep = ^REP_LAST;
`endif

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    case (state)
      IDLE: begin
        if (manual_req) begin
          state_nxt   = FIRE;
          counter_nxt = 8'd0;
        end else if (sensor_sync) begin
          if (DEB_ONE) begin
            state_nxt   = FIRE;
            counter_nxt = 8'd0;
          end else begin
            state_nxt   = QUALIFY;
            counter_nxt = 8'd1;
          end
        end
      end
      QUALIFY: begin
        if (manual_req) begin
          state_nxt   = FIRE;
          counter_nxt = 8'd0;
        end else if (!sensor_sync) begin
          state_nxt   = IDLE;
          counter_nxt = 8'd0;
        end else if (counter == DEB_LAST) begin
          state_nxt   = FIRE;
          counter_nxt = 8'd0;
        end else begin
          counter_nxt = counter + 8'd1;
        end
      end
      FIRE: begin
        state_nxt   = HOLD;
        counter_nxt = 8'd0;
      end
      HOLD: begin
        // manual_req is deliberately not looked at while the vehicle is still present
        if (!sensor_sync) begin
          if (COOL_NONE) begin
            state_nxt   = IDLE;
            counter_nxt = 8'd0;
          end else begin
            state_nxt   = COOLDOWN;
            counter_nxt = COOL_LOAD;
          end
        end
`ifdef PREEMPT_REPEAT_EN
        else if (counter == REP_LAST) begin
          state_nxt   = FIRE;
          counter_nxt = 8'd0;
        end else begin
          counter_nxt = counter + 8'd1;
        end
`endif
      end
      COOLDOWN: begin
        if (counter == 8'd1) begin
          state_nxt   = IDLE;
          counter_nxt = 8'd0;
        end else begin
          counter_nxt = counter - 8'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = 8'd0;
      end
    endcase
  end

  // FIRE always exits to HOLD, so emergency can never be high on two adjacent cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= 8'd0;
      emergency     <= 1'b0;
      busy          <= 1'b0;
      preempt_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      counter   <= counter_nxt;
      emergency <= (state_nxt == FIRE);
      busy      <= (state_nxt != IDLE);
      if (state_nxt == FIRE && preempt_count != 8'hFF) begin
        preempt_count <= preempt_count + 8'd1;
      end
    end
  end

endmodule
